// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the RV32I multi-cycle control unit.
// Holds the FSM state enum, major opcodes, instruction classes, datapath select
// encodings and fault codes used by multicycle_control_unit and opcode_classifier.
package ctrl_pkg;

   // FSM states
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   // Major opcodes (instruction bits [6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Instruction classes produced by opcode_classifier
   typedef enum logic [3:0] {
      CLS_NONE   = 4'd0,
      CLS_R      = 4'd1,
      CLS_I      = 4'd2,
      CLS_LOAD   = 4'd3,
      CLS_STORE  = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_JAL    = 4'd6,
      CLS_JALR   = 4'd7,
      CLS_LUI    = 4'd8
   } op_class_t;

   // alu_op encodings
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_RFUNCT = 2'b10;
   localparam logic [1:0] ALU_IFUNCT = 2'b11;

   // alu_src_a encodings
   localparam logic [1:0] SRCA_PC   = 2'b00;
   localparam logic [1:0] SRCA_RS1  = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   // alu_src_b encodings
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // pc_src encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JALR   = 2'b10;

   // mem_to_reg encodings
   localparam logic [1:0] WBSEL_ALU = 2'b00;
   localparam logic [1:0] WBSEL_MEM = 2'b01;
   localparam logic [1:0] WBSEL_PC4 = 2'b10;

   // fault_code values
   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps a 7-bit RV32I opcode to an instruction class plus illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input every cycle.
// Ports: opcode (in, 7) -> op_class (out, 4, ctrl_pkg::op_class_t value), illegal (out, 1).
// Macro CTRL_JUMP_EN: when defined, JAL/JALR/LUI are legal; otherwise they classify as illegal.
module opcode_classifier
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [3:0] op_class,
   output logic       illegal
);

   op_class_t cls;

   always_comb begin
      cls = CLS_NONE;
      case (opcode)
         OP_R:      cls = CLS_R;
         OP_I:      cls = CLS_I;
         OP_LOAD:   cls = CLS_LOAD;
         OP_STORE:  cls = CLS_STORE;
         OP_BRANCH: cls = CLS_BRANCH;
`ifdef CTRL_JUMP_EN
         OP_JAL:    cls = CLS_JAL;
         OP_JALR:   cls = CLS_JALR;
         OP_LUI:    cls = CLS_LUI;
`endif
         default:   cls = CLS_NONE;
      endcase
   end

   assign op_class = cls;
   assign illegal  = (cls == CLS_NONE);

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Latency: R/I/LUI/store/JAL/JALR 4 cycles, load 5, branch 3, plus one per memory wait cycle.
// Backpressure: mem_ready stalls FETCH/MEM; MEM_TIMEOUT consecutive waits trap with fault 10.
// Ports: clk, reset (sync, active-high); opcode, mem_ready in; mem_req, iord, mem_read,
//   mem_write, ir_write, pc_write, branch, pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg,
//   reg_write, trap, fault_code out. All outputs are forced to 0 while reset is high.
// Macro CTRL_JUMP_EN: enables JAL/JALR/LUI; without it they trap as illegal opcodes.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int ALUOP_W     = 2
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               pc_write,
   output logic               branch,
   output logic [1:0]         pc_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         mem_to_reg,
   output logic               reg_write,
   output logic               trap,
   output logic [1:0]         fault_code
);

   // Counter must hold 0..MEM_TIMEOUT; keep at least one bit when the timeout is disabled.
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   // Trap fires when the count is about to reach MEM_TIMEOUT with mem_ready still low.
   localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

   state_t           state_q, state_d;
   logic [6:0]       op_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       fault_q, fault_d;

   logic [6:0]       cls_in;
   logic [3:0]       cls_raw;
   op_class_t        cls;
   logic             illegal;
   logic             mem_state;
   logic             timeout;
   logic [1:0]       aop;

   // In DECODE the live opcode is classified (legality check); afterwards the latched one.
   assign cls_in = (state_q == DECODE) ? opcode : op_q;

   opcode_classifier u_classifier (
      .opcode   (cls_in),
      .op_class (cls_raw),
      .illegal  (illegal)
   );

   assign cls       = op_class_t'(cls_raw);
   assign mem_state = (state_q == FETCH) || (state_q == MEM);
   assign timeout   = TIMEOUT_EN && mem_state && !mem_ready && (cnt_q == CNT_LAST);

   // Next-state and fault capture
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      case (state_q)
         FETCH: begin
            if (mem_ready) begin
               state_d = DECODE;
            end else if (timeout) begin
               state_d = TRAP;
               fault_d = FAULT_TIMEOUT;
            end
         end
         DECODE: begin
            if (illegal) begin
               state_d = TRAP;
               fault_d = FAULT_ILLEGAL;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            case (cls)
               CLS_R, CLS_I:         state_d = WB;
               CLS_LOAD, CLS_STORE:  state_d = MEM;
               CLS_BRANCH:           state_d = FETCH;
`ifdef CTRL_JUMP_EN
               CLS_JAL, CLS_JALR, CLS_LUI: state_d = WB;
`endif
               default: begin
                  // op_q was legal in DECODE, so this arm only guards against corruption
                  state_d = TRAP;
                  fault_d = FAULT_ILLEGAL;
               end
            endcase
         end
         MEM: begin
            if (mem_ready) begin
               state_d = (cls == CLS_LOAD) ? WB : FETCH;
            end else if (timeout) begin
               state_d = TRAP;
               fault_d = FAULT_TIMEOUT;
            end
         end
         WB:      state_d = FETCH;
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         if (state_q == DECODE) begin
            op_q <= opcode;
         end
         // Any state change clears the counter, so FETCH and MEM always start from 0.
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (mem_state && !mem_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Moore outputs (FETCH enables additionally qualified by mem_ready); all zero in reset.
   always_comb begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      pc_src     = PCSRC_ALU;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      aop        = ALU_ADD;
      mem_to_reg = WBSEL_ALU;
      reg_write  = 1'b0;
      trap       = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               mem_req   = 1'b1;
               mem_read  = 1'b1;
               alu_src_a = SRCA_PC;
               alu_src_b = SRCB_FOUR;
               aop       = ALU_ADD;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE: begin
               alu_src_a = SRCA_PC;
               alu_src_b = SRCB_IMM;
               aop       = ALU_ADD;
            end
            EXEC: begin
               case (cls)
                  CLS_R: begin
                     alu_src_a = SRCA_RS1;
                     alu_src_b = SRCB_RS2;
                     aop       = ALU_RFUNCT;
                  end
                  CLS_I: begin
                     alu_src_a = SRCA_RS1;
                     alu_src_b = SRCB_IMM;
                     aop       = ALU_IFUNCT;
                  end
                  CLS_LOAD, CLS_STORE: begin
                     alu_src_a = SRCA_RS1;
                     alu_src_b = SRCB_IMM;
                     aop       = ALU_ADD;
                  end
                  CLS_BRANCH: begin
                     alu_src_a = SRCA_RS1;
                     alu_src_b = SRCB_RS2;
                     aop       = ALU_SUB;
                     branch    = 1'b1;
                     pc_src    = PCSRC_ALUOUT;
                  end
`ifdef CTRL_JUMP_EN
                  CLS_JAL: begin
                     // Target was computed into the ALU result register during DECODE
                     pc_write = 1'b1;
                     pc_src   = PCSRC_ALUOUT;
                  end
                  CLS_JALR: begin
                     alu_src_a = SRCA_RS1;
                     alu_src_b = SRCB_IMM;
                     pc_src    = PCSRC_JALR;
                     pc_write  = 1'b1;
                  end
                  CLS_LUI: begin
                     alu_src_a = SRCA_ZERO;
                     alu_src_b = SRCB_IMM;
                     aop       = ALU_ADD;
                  end
`endif
                  default: ;
               endcase
            end
            MEM: begin
               mem_req   = 1'b1;
               iord      = 1'b1;
               mem_read  = (cls == CLS_LOAD);
               mem_write = (cls == CLS_STORE);
            end
            WB: begin
               reg_write = 1'b1;
               if (cls == CLS_LOAD) begin
                  mem_to_reg = WBSEL_MEM;
               end else if ((cls == CLS_JAL) || (cls == CLS_JALR)) begin
                  mem_to_reg = WBSEL_PC4;
               end
            end
            TRAP:    trap = 1'b1;
            default: ;
         endcase
      end
   end

   assign alu_op     = ALUOP_W'(aop);
   assign fault_code = reset ? FAULT_NONE : fault_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed per-cycle vectors with queued expectations.
// Each stimulus cycle pushes the expected output vector; a monitor pops and compares on negedge.
// Honours CTRL_JUMP_EN so the same bench fits either build of the design.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic [1:0] pc_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       trap;
      logic [1:0] fault_code;
   } outs_t;

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LD   = 7'b0000011;
   localparam logic [6:0] OPC_ST   = 7'b0100011;
   localparam logic [6:0] OPC_BR   = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [6:0] OPC_LUI  = 7'b0110111;
   localparam logic [6:0] OPC_BAD  = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, iord, mem_read, mem_write, ir_write, pc_write, branch;
   logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, fault_code;
   logic       reg_write, trap;

   outs_t act_w;
   outs_t exp_q[$];
   string name_q[$];
   int    errors = 0;
   int    checks = 0;

   outs_t X_ZERO, X_FETCH, X_FETCH_RDY, X_DECODE, X_EX_R, X_EX_I, X_EX_LS, X_EX_BR;
   outs_t X_EX_JAL, X_EX_JALR, X_EX_LUI, X_MEM_LD, X_MEM_ST, X_WB_ALU, X_WB_LD, X_WB_J;
   outs_t X_TRAP_ILL, X_TRAP_TO;

   always #5 clk = ~clk;

   multicycle_control_unit #(.MEM_TIMEOUT(16), .ALUOP_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .branch     (branch),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .trap       (trap),
      .fault_code (fault_code)
   );

   assign act_w = {mem_req, iord, mem_read, mem_write, ir_write, pc_write, branch, pc_src,
                   alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, trap, fault_code};

   // One stimulus cycle: drive inputs just after the edge and queue the expected outputs.
   task automatic cyc(input logic r, input logic [6:0] op, input logic rdy,
                      input outs_t e, input string nm);
      @(posedge clk);
      #1;
      reset     = r;
      opcode    = op;
      mem_ready = rdy;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Four-cycle instruction with zero wait states: FETCH, DECODE, EXEC, WB.
   task automatic run4(input logic [6:0] op, input outs_t ex, input outs_t wb, input string nm);
      cyc(1'b0, op, 1'b1, X_FETCH_RDY, {nm, "_fetch"});
      cyc(1'b0, op, 1'b1, X_DECODE,    {nm, "_decode"});
      cyc(1'b0, op, 1'b1, ex,          {nm, "_exec"});
      cyc(1'b0, op, 1'b1, wb,          {nm, "_wb"});
   endtask

   // Monitor: compare DUT outputs against the queued expectation mid-cycle.
   initial begin
      outs_t e;
      string n;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act_w !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h (t=%0t)", n, act_w, e, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      X_ZERO = '0;
      X_FETCH = '0;
      X_FETCH.mem_req = 1'b1; X_FETCH.mem_read = 1'b1; X_FETCH.alu_src_b = 2'b10;
      X_FETCH_RDY = X_FETCH;
      X_FETCH_RDY.ir_write = 1'b1; X_FETCH_RDY.pc_write = 1'b1;
      X_DECODE = '0;  X_DECODE.alu_src_b = 2'b01;
      X_EX_R = '0;    X_EX_R.alu_src_a = 2'b01; X_EX_R.alu_op = 2'b10;
      X_EX_I = '0;    X_EX_I.alu_src_a = 2'b01; X_EX_I.alu_src_b = 2'b01; X_EX_I.alu_op = 2'b11;
      X_EX_LS = '0;   X_EX_LS.alu_src_a = 2'b01; X_EX_LS.alu_src_b = 2'b01;
      X_EX_BR = '0;   X_EX_BR.alu_src_a = 2'b01; X_EX_BR.alu_op = 2'b01;
      X_EX_BR.branch = 1'b1; X_EX_BR.pc_src = 2'b01;
      X_EX_JAL = '0;  X_EX_JAL.pc_write = 1'b1; X_EX_JAL.pc_src = 2'b01;
      X_EX_JALR = '0; X_EX_JALR.alu_src_a = 2'b01; X_EX_JALR.alu_src_b = 2'b01;
      X_EX_JALR.pc_src = 2'b10; X_EX_JALR.pc_write = 1'b1;
      X_EX_LUI = '0;  X_EX_LUI.alu_src_a = 2'b10; X_EX_LUI.alu_src_b = 2'b01;
      X_MEM_LD = '0;  X_MEM_LD.mem_req = 1'b1; X_MEM_LD.iord = 1'b1; X_MEM_LD.mem_read = 1'b1;
      X_MEM_ST = '0;  X_MEM_ST.mem_req = 1'b1; X_MEM_ST.iord = 1'b1; X_MEM_ST.mem_write = 1'b1;
      X_WB_ALU = '0;  X_WB_ALU.reg_write = 1'b1;
      X_WB_LD = X_WB_ALU; X_WB_LD.mem_to_reg = 2'b01;
      X_WB_J = X_WB_ALU;  X_WB_J.mem_to_reg = 2'b10;
      X_TRAP_ILL = '0; X_TRAP_ILL.trap = 1'b1; X_TRAP_ILL.fault_code = 2'b01;
      X_TRAP_TO = '0;  X_TRAP_TO.trap = 1'b1;  X_TRAP_TO.fault_code = 2'b10;

      // Reset: outputs all zero even with mem_ready high
      cyc(1'b1, OPC_R, 1'b1, X_ZERO, "reset0");
      cyc(1'b1, OPC_R, 1'b1, X_ZERO, "reset1");

      // R-type and I-type, no waits
      run4(OPC_R, X_EX_R, X_WB_ALU, "r");
      run4(OPC_I, X_EX_I, X_WB_ALU, "i");

      // Fetch with two wait cycles: request held, no enables until ready
      cyc(1'b0, OPC_R, 1'b0, X_FETCH, "fwait0");
      cyc(1'b0, OPC_R, 1'b0, X_FETCH, "fwait1");
      run4(OPC_R, X_EX_R, X_WB_ALU, "r_after_wait");

      // Load with three MEM wait cycles: 8 cycles total
      cyc(1'b0, OPC_LD, 1'b1, X_FETCH_RDY, "ld_fetch");
      cyc(1'b0, OPC_LD, 1'b1, X_DECODE,    "ld_decode");
      cyc(1'b0, OPC_LD, 1'b1, X_EX_LS,     "ld_exec");
      for (int k = 0; k < 3; k++) cyc(1'b0, OPC_LD, 1'b0, X_MEM_LD, "ld_mem_wait");
      cyc(1'b0, OPC_LD, 1'b1, X_MEM_LD,    "ld_mem_rdy");
      cyc(1'b0, OPC_LD, 1'b1, X_WB_LD,     "ld_wb");

      // Store, no waits: back to FETCH after MEM
      cyc(1'b0, OPC_ST, 1'b1, X_FETCH_RDY, "st_fetch");
      cyc(1'b0, OPC_ST, 1'b1, X_DECODE,    "st_decode");
      cyc(1'b0, OPC_ST, 1'b1, X_EX_LS,     "st_exec");
      cyc(1'b0, OPC_ST, 1'b1, X_MEM_ST,    "st_mem");

      // Branch: 3 cycles, then straight into the next FETCH
      cyc(1'b0, OPC_BR, 1'b1, X_FETCH_RDY, "br_fetch");
      cyc(1'b0, OPC_BR, 1'b1, X_DECODE,    "br_decode");
      cyc(1'b0, OPC_BR, 1'b1, X_EX_BR,     "br_exec");
      run4(OPC_R, X_EX_R, X_WB_ALU, "r_after_br");

`ifdef CTRL_JUMP_EN
      run4(OPC_JAL,  X_EX_JAL,  X_WB_J,   "jal");
      run4(OPC_JALR, X_EX_JALR, X_WB_J,   "jalr");
      run4(OPC_LUI,  X_EX_LUI,  X_WB_ALU, "lui");
`else
      // Jump/LUI opcodes are illegal in this build
      cyc(1'b0, OPC_JAL, 1'b1, X_FETCH_RDY, "jal_fetch");
      cyc(1'b0, OPC_JAL, 1'b1, X_DECODE,    "jal_decode");
      for (int k = 0; k < 3; k++) cyc(1'b0, OPC_JAL, 1'b1, X_TRAP_ILL, "jal_trap");
      cyc(1'b1, OPC_JAL, 1'b1, X_ZERO, "jal_reset");
      cyc(1'b0, OPC_LUI, 1'b1, X_FETCH_RDY, "lui_fetch");
      cyc(1'b0, OPC_LUI, 1'b1, X_DECODE,    "lui_decode");
      cyc(1'b0, OPC_LUI, 1'b1, X_TRAP_ILL,  "lui_trap");
      cyc(1'b1, OPC_LUI, 1'b1, X_ZERO, "lui_reset");
`endif

      // Reset mid-instruction (in DECODE): outputs zero, restart at FETCH
      cyc(1'b0, OPC_R, 1'b1, X_FETCH_RDY, "mid_fetch");
      cyc(1'b1, OPC_R, 1'b1, X_ZERO,      "mid_reset");
      run4(OPC_R, X_EX_R, X_WB_ALU, "r_after_midrst");

      // Illegal opcode: sticky trap for 100 cycles regardless of mem_ready
      cyc(1'b0, OPC_BAD, 1'b1, X_FETCH_RDY, "ill_fetch");
      cyc(1'b0, OPC_BAD, 1'b1, X_DECODE,    "ill_decode");
      for (int k = 0; k < 100; k++) cyc(1'b0, OPC_R, k[0], X_TRAP_ILL, "ill_trap");
      cyc(1'b1, OPC_R, 1'b1, X_ZERO, "ill_reset");
      run4(OPC_R, X_EX_R, X_WB_ALU, "r_after_ill");

      // FETCH timeout: 16 waiting cycles, then trap with fault 10
      for (int k = 0; k < 16; k++) cyc(1'b0, OPC_R, 1'b0, X_FETCH, "fto_wait");
      for (int k = 0; k < 3; k++) cyc(1'b0, OPC_R, 1'b1, X_TRAP_TO, "fto_trap");
      cyc(1'b1, OPC_R, 1'b1, X_ZERO, "fto_reset");

      // Ready on the 16th FETCH cycle counts as success
      for (int k = 0; k < 15; k++) cyc(1'b0, OPC_R, 1'b0, X_FETCH, "fedge_wait");
      cyc(1'b0, OPC_R, 1'b1, X_FETCH_RDY, "fedge_rdy");
      cyc(1'b0, OPC_R, 1'b1, X_DECODE,    "fedge_decode");
      cyc(1'b0, OPC_R, 1'b1, X_EX_R,      "fedge_exec");
      cyc(1'b0, OPC_R, 1'b1, X_WB_ALU,    "fedge_wb");

      // MEM timeout on a load
      cyc(1'b0, OPC_LD, 1'b1, X_FETCH_RDY, "mto_fetch");
      cyc(1'b0, OPC_LD, 1'b1, X_DECODE,    "mto_decode");
      cyc(1'b0, OPC_LD, 1'b1, X_EX_LS,     "mto_exec");
      for (int k = 0; k < 16; k++) cyc(1'b0, OPC_LD, 1'b0, X_MEM_LD, "mto_wait");
      for (int k = 0; k < 2; k++) cyc(1'b0, OPC_LD, 1'b1, X_TRAP_TO, "mto_trap");
      cyc(1'b1, OPC_LD, 1'b1, X_ZERO, "mto_reset");
      run4(OPC_R, X_EX_R, X_WB_ALU, "r_final");

      // Let the monitor drain the queue
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
